// File: rtl/axi_ram_pkg.sv
// Shared types, response/burst codes and the burst address-advance helper for axi_ram_slave.
package axi_ram_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } burst_t;

    // Reserved burst 2'b11 falls into the INCR default.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << size;
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            FIXED:   return addr;
            WRAP:    return (addr & ~mask) | ((addr + step) & mask);
            default: return addr + step;
        endcase
    endfunction

endpackage

// File: rtl/axi_ram_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as a stall pattern source.
module axi_ram_lfsr
    import axi_ram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= LFSR_SEED;
        else     q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 RAM responder: independent read/write FSMs, one outstanding burst per direction.
// Define AXI_SLAVE_RAND_STALL_EN to add LFSR-driven stalls on arready/awready/wready/rvalid.
module axi_ram_slave
    import axi_ram_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int READ_LAT  = 2,
    parameter int RESET_CLR = 0
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT_INIT = (READ_LAT > 1) ? 4'(READ_LAT - 2) : 4'd0;

    logic [31:0] mem [MEM_WORDS];

    logic unused_ok;
    assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    function automatic logic dec_err(input logic [31:0] a);
        return (a >> (AW + 2)) != 32'd0;
    endfunction

    // Bit 0..3 gate arready, awready, wready, rvalid.
    logic [3:0] stall_ok;
`ifdef AXI_SLAVE_RAND_STALL_EN
    logic [15:0] lfsr_q;
    logic [11:0] unused_lfsr;
    axi_ram_lfsr u_lfsr (.clk(aclk), .rst(areset), .q(lfsr_q));
    assign stall_ok    = lfsr_q[3:0];
    assign unused_lfsr = lfsr_q[15:4];
`else
    assign stall_ok = 4'hF;
`endif

    logic          clr_busy;
    logic [AW-1:0] clr_idx;

    always_ff @(posedge aclk) begin
        if (areset) begin
            clr_busy <= (RESET_CLR != 0);
            clr_idx  <= '0;
        end else if (clr_busy) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == '1) clr_busy <= 1'b0;
        end
    end

    // ---------------- read path ----------------
    rd_state_t   r_state, r_next;
    burst_t      r_ctx;
    logic [7:0]  r_left;
    logic [3:0]  r_wait_cnt;
    logic        r_held;
    logic        ar_hs, r_hs, r_fetch, r_fetch_last;
    logic [31:0] r_fetch_addr;

    assign rid = r_ctx.id;

    always_comb begin
        r_next       = r_state;
        arready      = 1'b0;
        rvalid       = 1'b0;
        r_fetch      = 1'b0;
        r_fetch_last = 1'b0;
        r_fetch_addr = r_ctx.addr;
        case (r_state)
            R_IDLE: begin
                arready = !clr_busy && stall_ok[0];
                if (arvalid && arready) begin
                    r_next = (READ_LAT == 1) ? R_DATA : R_WAIT;
                    if (READ_LAT == 1) begin
                        r_fetch      = 1'b1;
                        r_fetch_addr = araddr;
                        r_fetch_last = (arlen == 8'd0);
                    end
                end
            end
            R_WAIT: if (r_wait_cnt == 4'd0) begin
                r_next       = R_DATA;
                r_fetch      = 1'b1;
                r_fetch_last = (r_left == 8'd0);
            end
            R_DATA: begin
                // Once shown, rvalid stays up regardless of the stall source.
                rvalid = r_held || stall_ok[3];
                if (rvalid && rready) begin
                    if (rlast) begin
                        r_next = R_IDLE;
                    end else begin
                        r_fetch      = 1'b1;
                        r_fetch_addr = next_addr(r_ctx.addr, r_ctx.size, r_ctx.len, r_ctx.burst);
                        r_fetch_last = (r_left == 8'd1);
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= R_IDLE;
            r_ctx      <= '0;
            r_left     <= '0;
            r_wait_cnt <= '0;
            r_held     <= 1'b0;
            rdata      <= '0;
            rresp      <= OKAY;
            rlast      <= 1'b0;
        end else begin
            r_state <= r_next;
            r_held  <= rvalid && !rready;
            if (ar_hs) begin
                r_ctx      <= '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
                r_left     <= arlen;
                r_wait_cnt <= WAIT_INIT;
            end else if (r_state == R_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (r_hs) r_left <= r_left - 8'd1;
            // Fetch is registered here, so a same-cycle write to this word is not seen.
            if (r_fetch) begin
                r_ctx.addr <= r_fetch_addr;
                rdata      <= dec_err(r_fetch_addr) ? 32'd0 : mem[r_fetch_addr[AW+1:2]];
                rresp      <= dec_err(r_fetch_addr) ? DECERR : OKAY;
                rlast      <= r_fetch_last;
            end
        end
    end

    // ---------------- write path ----------------
    wr_state_t w_state, w_next;
    burst_t    w_ctx;
    logic [7:0] w_left;
    logic      aw_hs, w_hs, w_dec;

    assign bid   = w_ctx.id;
    assign w_dec = dec_err(w_ctx.addr);

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = !clr_busy && stall_ok[1];
                if (awvalid && awready) w_next = W_DATA;
            end
            W_DATA: begin
                wready = stall_ok[2];
                if (wvalid && wready && w_left == 8'd0) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_ctx   <= '0;
            w_left  <= '0;
            bresp   <= OKAY;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_ctx  <= '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
                w_left <= awlen;
                bresp  <= OKAY;
            end
            if (w_hs) begin
                w_ctx.addr <= next_addr(w_ctx.addr, w_ctx.size, w_ctx.len, w_ctx.burst);
                w_left     <= w_left - 8'd1;
                // DECERR dominates; wlast is only a consistency check against the beat count.
                if (w_dec)
                    bresp <= DECERR;
                else if ((wlast != (w_left == 8'd0)) && bresp != DECERR)
                    bresp <= SLVERR;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (clr_busy) begin
            mem[clr_idx] <= '0;
        end else if (w_hs && !w_dec) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[w_ctx.addr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

endmodule
